// File: rtl/pll_pkg.sv
// ============================================================================
// Module   : pll_pkg
// Brief    : Shared FSM state encoding and default timing constants for the
//            PLL lock qualifier and reset generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_pkg;

    localparam int unsigned c_SYNC_STAGES_DEFAULT   = 2;
    localparam int unsigned c_STABLE_CYCLES_DEFAULT = 4800;
    localparam int unsigned c_HOLD_CYCLES_DEFAULT   = 16;
    localparam int unsigned c_CNT_W_DEFAULT         = 16;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RUN       = 3'd3,
        ST_LOST      = 3'd4
    } pll_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// ============================================================================
// Module   : sync_ff
// Brief    : Single-bit multi-flop synchronizer, async active-low reset to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_ff #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] sync_q;
    logic [DEPTH-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[DEPTH-2:0], i_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/pll_lock_reset_gen.sv
// ============================================================================
// Module   : pll_lock_reset_gen
// Brief    : Qualifies PLL lock over a stable window, then releases a
//            registered system reset; tracks lock-loss events.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_reset_gen
    import pll_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = c_SYNC_STAGES_DEFAULT,
    parameter int unsigned STABLE_CYCLES = c_STABLE_CYCLES_DEFAULT,
    parameter int unsigned HOLD_CYCLES   = c_HOLD_CYCLES_DEFAULT,
    parameter int unsigned CNT_W         = c_CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       clear_lost,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       lost_flag,
    output logic [7:0] lost_cnt
);

    localparam logic [CNT_W-1:0] c_STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

    logic             w_locked_s;
    logic             w_loss;
    pll_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sys_rst_n_q, sys_rst_n_d;
    logic             ready_q, ready_d;
    logic             lost_flag_q, lost_flag_d;
    logic [7:0]       lost_cnt_q, lost_cnt_d;

    sync_ff #(
        .DEPTH (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (locked),
        .o_q   (w_locked_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_loss  = 1'b0;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (w_locked_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            end
            // A drop during qualification only restarts it; it is not a loss.
            ST_STABLE: begin
                if (!w_locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == c_STABLE_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (!w_locked_s) begin
                    state_d = ST_LOST;
                    cnt_d   = '0;
                    w_loss  = 1'b1;
                end else if (cnt_q == c_HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!w_locked_s) begin
                    state_d = ST_LOST;
                    cnt_d   = '0;
                    w_loss  = 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase

        // A loss on the same edge as a clear wins and counts as the first event.
        lost_flag_d = lost_flag_q;
        lost_cnt_d  = lost_cnt_q;
        if (w_loss) begin
            lost_flag_d = 1'b1;
            if (clear_lost) begin
                lost_cnt_d = 8'd1;
            end else if (lost_cnt_q != 8'hFF) begin
                lost_cnt_d = lost_cnt_q + 8'd1;
            end
        end else if (clear_lost) begin
            lost_flag_d = 1'b0;
            lost_cnt_d  = 8'd0;
        end

        sys_rst_n_d = (state_d == ST_RUN);
        ready_d     = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_WAIT_LOCK;
            cnt_q       <= '0;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            lost_flag_q <= 1'b0;
            lost_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            lost_flag_q <= lost_flag_d;
            lost_cnt_q  <= lost_cnt_d;
        end
    end

    assign sys_rst_n = sys_rst_n_q;
    assign ready     = ready_q;
    assign lost_flag = lost_flag_q;
    assign lost_cnt  = lost_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_reset_gen.sv
// ============================================================================
// Module   : tb_pll_lock_reset_gen
// Brief    : Self-checking bench for pll_lock_reset_gen against a lock-streak
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_lock_reset_gen;

    localparam int SYNC   = 2;
    localparam int STABLE = 8;
    localparam int HOLD   = 4;
    localparam int RUN_AT = STABLE + HOLD + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       locked;
    logic       clear_lost;
    logic       sys_rst_n;
    logic       ready;
    logic       lost_flag;
    logic [7:0] lost_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: FSM-visible lock history as a streak of high samples
    int m_sync [SYNC];
    int m_streak;
    bit m_skip;
    bit m_run;
    int m_cnt;
    bit m_flag;

    pll_lock_reset_gen #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .HOLD_CYCLES   (HOLD),
        .CNT_W         (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .locked     (locked),
        .clear_lost (clear_lost),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .lost_flag  (lost_flag),
        .lost_cnt   (lost_cnt)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) m_sync[i] = 0;
        m_streak = 0;
        m_skip   = 1'b0;
        m_run    = 1'b0;
        m_cnt    = 0;
        m_flag   = 1'b0;
    endtask

    task automatic model_edge(input bit lk, input bit clr);
        bit s;
        bit loss;
        s    = (m_sync[SYNC-1] != 0);
        loss = 1'b0;
        for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = lk;
        if (m_skip) begin
            m_skip   = 1'b0;
            m_streak = 0;
        end else if (s) begin
            if (m_streak < RUN_AT) m_streak++;
        end else begin
            if (m_streak >= STABLE + 1) begin
                loss   = 1'b1;
                m_skip = 1'b1;
            end
            m_streak = 0;
        end
        m_run = !m_skip && (m_streak >= RUN_AT);
        if (loss) begin
            m_flag = 1'b1;
            m_cnt  = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        end else if (clr) begin
            m_flag = 1'b0;
            m_cnt  = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(locked, clear_lost);
        #1;
        check("sys_rst_n", 32'(sys_rst_n), 32'(m_run));
        check("ready",     32'(ready),     32'(m_run));
        check("lost_flag", 32'(lost_flag), 32'(m_flag));
        check("lost_cnt",  32'(lost_cnt),  32'(m_cnt));
    endtask

    task automatic count_to_run(input string tag);
        int first;
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (sys_rst_n === 1'b1) begin
                first = i;
                break;
            end
        end
        check(tag, 32'(first), 32'(15));
    endtask

    task automatic async_reset_pulse();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_sys_rst_n", 32'(sys_rst_n), 32'(0));
        check("async_rst_ready",     32'(ready),     32'(0));
        check("async_rst_lost_cnt",  32'(lost_cnt),  32'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt_before;
        rst_n      = 1'b0;
        locked     = 1'b0;
        clear_lost = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_sys_rst_n", 32'(sys_rst_n), 32'(0));
        check("rst_ready",     32'(ready),     32'(0));
        check("rst_lost_flag", 32'(lost_flag), 32'(0));
        check("rst_lost_cnt",  32'(lost_cnt),  32'(0));
        rst_n  = 1'b1;
        locked = 1'b1;

        count_to_run("first_run_edge");
        repeat (5) step();

        // Loss from RUN: visible two edges after locked falls
        locked = 1'b0;
        step();
        step();
        check("loss_edge_n1_sys_rst_n", 32'(sys_rst_n), 32'(1));
        step();
        check("loss_sys_rst_n",  32'(sys_rst_n), 32'(0));
        check("loss_lost_flag",  32'(lost_flag), 32'(1));
        check("loss_lost_cnt",   32'(lost_cnt),  32'(1));
        locked = 1'b1;
        count_to_run("relock_run_edge");

        // Short drop in STABLE restarts qualification without a loss
        locked = 1'b0;
        repeat (6) step();
        cnt_before = m_cnt;
        locked = 1'b1;
        repeat (6) step();
        locked = 1'b0;
        repeat (3) step();
        locked = 1'b1;
        count_to_run("stable_drop_requal");
        check("stable_drop_no_loss", 32'(lost_cnt), 32'(cnt_before));

        // Random lock bursts with occasional clears
        for (int seg = 0; seg < 250; seg++) begin
            int len;
            locked = 1'($urandom_range(0, 1));
            len    = int'($urandom_range(1, 18));
            for (int k = 0; k < len; k++) begin
                clear_lost = ($urandom_range(0, 15) == 0);
                step();
            end
        end
        clear_lost = 1'b0;

        // Saturation: 262 losses from HOLD/RUN
        locked = 1'b0;
        repeat (5) step();
        for (int r = 0; r < 262; r++) begin
            locked = 1'b1;
            repeat (11) step();
            locked = 1'b0;
            repeat (3) step();
        end
        check("sat_lost_cnt",  32'(lost_cnt),  32'(255));
        check("sat_lost_flag", 32'(lost_flag), 32'(1));
        clear_lost = 1'b1;
        step();
        clear_lost = 1'b0;
        check("clear_lost_cnt",  32'(lost_cnt),  32'(0));
        check("clear_lost_flag", 32'(lost_flag), 32'(0));

        // Clear coincident with a loss: the loss wins
        locked = 1'b1;
        repeat (20) step();
        locked = 1'b0;
        step();
        step();
        clear_lost = 1'b1;
        step();
        clear_lost = 1'b0;
        check("clear_vs_loss_cnt",  32'(lost_cnt),  32'(1));
        check("clear_vs_loss_flag", 32'(lost_flag), 32'(1));

        // Asynchronous reset while running
        locked = 1'b1;
        repeat (20) step();
        check("pre_reset_run", 32'(sys_rst_n), 32'(1));
        async_reset_pulse();
        count_to_run("post_reset_run_edge");
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pll_lock_reset_gen.md
PLL_LOCK_RESET_GEN -- requirements
Module: pll_lock_reset_gen

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flops in the lock synchronizer (min 2).
REQ-002 Parameter STABLE_CYCLES, default 4800: consecutive synchronized-lock cycles required (100 us at 48 MHz).
REQ-003 Parameter HOLD_CYCLES, default 16: cycles sys_rst_n stays low after lock is qualified.
REQ-004 Parameter CNT_W, default 16: qualification counter width; must hold max(STABLE_CYCLES, HOLD_CYCLES)-1.
REQ-005 clk  input  1  48 MHz PLL output clock; the single clock of the block.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 locked  input  1  PLL LOCK output, asynchronous to clk.
REQ-008 clear_lost  input  1  synchronous pulse; clears lost_cnt and lost_flag.
REQ-009 sys_rst_n  output  1  registered, active-low reset for downstream 48 MHz logic.
REQ-010 ready  output  1  registered; high only in RUN.
REQ-011 lost_flag  output  1  sticky; set on any loss of lock from HOLD or RUN.
REQ-012 lost_cnt  output  8  saturating count of lock-loss events from HOLD or RUN.

Function
REQ-013 locked SHALL pass through a SYNC_STAGES-flop synchronizer; its last stage (locked_s) is the only lock signal the FSM uses.
REQ-014 FSM states: WAIT_LOCK, STABLE, HOLD, RUN, LOST.
REQ-015 WAIT_LOCK: locked_s=1 -> STABLE with cnt=0; else stay.
REQ-016 STABLE: locked_s=0 -> WAIT_LOCK (qualification restarts); cnt==STABLE_CYCLES-1 -> HOLD with cnt=0; else cnt+1.
REQ-017 HOLD: locked_s=0 -> LOST; cnt==HOLD_CYCLES-1 -> RUN; else cnt+1.
REQ-018 RUN: locked_s=0 -> LOST; else stay.
REQ-019 LOST: unconditionally -> WAIT_LOCK on the next edge.
REQ-020 sys_rst_n and ready SHALL be 1 exactly while state is RUN, registered on the same edge as the state transition (no extra cycle).
REQ-021 First RUN edge SHALL be SYNC_STAGES+1+STABLE_CYCLES+HOLD_CYCLES edges after the first edge sampling locked=1, given locked stays high.
REQ-022 On a RUN->LOST or HOLD->LOST edge: sys_rst_n=0, ready=0, lost_flag=1, lost_cnt+1 saturating at 255, all on that edge.
REQ-023 clear_lost=1 SHALL zero lost_cnt and lost_flag next edge; if a loss event occurs on the same edge, the loss wins: lost_cnt=1, lost_flag=1.
REQ-024 A locked pulse shorter than SYNC_STAGES cycles may be missed; any locked_s drop in STABLE SHALL not count as a loss.
REQ-025 cnt SHALL never wrap; it resets on every state entry.

Reset
REQ-026 rst_n low SHALL asynchronously force: state=WAIT_LOCK, cnt=0, synchronizer flops=0, sys_rst_n=0, ready=0, lost_flag=0, lost_cnt=0.
REQ-027 rst_n assertion mid-operation (any state) SHALL drop sys_rst_n immediately; after release, qualification restarts from WAIT_LOCK.

Structure
REQ-028 Shared package pll_pkg SHALL hold the FSM state enum and default constants (SYNC_STAGES, STABLE_CYCLES, HOLD_CYCLES).
REQ-029 The synchronizer SHALL be sub-module sync_ff (parameterized depth, async active-low reset to 0); the FSM and counters stay in pll_lock_reset_gen.

Verification (STABLE_CYCLES=8, HOLD_CYCLES=4, SYNC_STAGES=2)
REQ-030 locked rises before edge 1 and holds -> sys_rst_n and ready rise at edge 15, not earlier; lost_cnt=0.
REQ-031 In RUN, locked falls before edge n -> sys_rst_n=0, lost_flag=1, lost_cnt=1 at edge n+2; state WAIT_LOCK at edge n+3; relock -> RUN again after 15 edges.
REQ-032 locked low for 3 cycles mid-STABLE -> back to WAIT_LOCK, lost_cnt stays 0, full 8-cycle qualification restarts.
REQ-033 260 loss events -> lost_cnt saturates at 255; clear_lost pulse -> lost_cnt=0, lost_flag=0; clear_lost coincident with a loss -> lost_cnt=1.
REQ-034 rst_n pulsed low in RUN -> sys_rst_n=0 asynchronously; after release with locked high, sys_rst_n rises 15 edges later.
